// File: rtl/imgproc_seq.sv
// Command sequencer for the image-processing datapath: decodes a host command, then
// runs pass 0 (orig -> stage -> temp) and pass 1 (temp -> orig). Optional watchdog: IMGPROC_SEQ_WATCHDOG_EN.
module imgproc_seq #(
  parameter int unsigned ANGLE_MAX = 90,
  parameter int unsigned TIMEOUT   = 262143
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ack,
  output logic       busy,
  output logic       refresh,
  output logic       error,
  output logic [1:0] op_sel,
  output logic [6:0] angle,
  output logic       p0_start,
  input  logic       p0_done,
  output logic       p1_start,
  input  logic       p1_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_P0_GO, S_P0_WAIT, S_P1_GO, S_P1_WAIT, S_FIN
  } state_t;

  typedef enum logic [3:0] {
    OP_ROTATE = 4'd0,
    OP_GRAY   = 4'd1,
    OP_COPY   = 4'd2
  } opcode_t;

  state_t     r_state, w_next;
  logic [3:0] r_cmd;
  logic [7:0] r_data;
  logic       r_p0_done, r_p1_done;
  logic       r_busy, r_error;
  logic [1:0] r_op_sel;
  logic [6:0] r_angle;
  logic       w_illegal, w_timeout, w_abort;

  assign w_illegal = (r_cmd > OP_COPY) ||
                     ((r_cmd == OP_ROTATE) && (32'(r_data) > ANGLE_MAX));

`ifdef IMGPROC_SEQ_WATCHDOG_EN
  logic [17:0] r_wd;
  logic        w_in_wait, w_go;

  assign w_in_wait = (r_state == S_P0_WAIT) || (r_state == S_P1_WAIT);
  assign w_go      = (r_state == S_P0_GO)   || (r_state == S_P1_GO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_wd <= '0;
    else if (w_go)                      r_wd <= '0;
    else if (w_in_wait && (r_wd != '1)) r_wd <= r_wd + 18'd1;
  end

  // Fires on the edge that would bring the count to TIMEOUT.
  assign w_timeout = w_in_wait && ((19'(r_wd) + 19'd1) >= 19'(TIMEOUT));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  assign w_abort = w_timeout && (((r_state == S_P0_WAIT) && !r_p0_done) ||
                                 ((r_state == S_P1_WAIT) && !r_p1_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    cmd_ack  = 1'b0;
    p0_start = 1'b0;
    p1_start = 1'b0;
    refresh  = 1'b0;
    case (r_state)
      S_IDLE:    if (cmd_valid) w_next = S_DECODE;
      S_DECODE: begin
        cmd_ack = 1'b1;
        if (w_illegal)             w_next = S_IDLE;
        else if (r_cmd == OP_COPY) w_next = S_P1_GO;
        else                       w_next = S_P0_GO;
      end
      S_P0_GO: begin
        p0_start = 1'b1;
        w_next   = S_P0_WAIT;
      end
      S_P0_WAIT: begin
        if (r_p0_done)      w_next = S_P1_GO;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_P1_GO: begin
        p1_start = 1'b1;
        w_next   = S_P1_WAIT;
      end
      S_P1_WAIT: begin
        if (r_p1_done)      w_next = S_FIN;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_FIN: begin
        refresh = 1'b1;
        w_next  = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Done pulses are registered only inside their own WAIT state, so a pulse
  // coincident with the start strobe (still in the GO state) is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd     <= '0;
      r_data    <= '0;
      r_p0_done <= 1'b0;
      r_p1_done <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_op_sel  <= '0;
      r_angle   <= '0;
    end else begin
      r_p0_done <= p0_done && (r_state == S_P0_WAIT);
      r_p1_done <= p1_done && (r_state == S_P1_WAIT);
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_cmd  <= cmd;
        r_data <= cmd_data;
      end
      if ((r_state == S_IDLE) && cmd_valid)               r_error <= 1'b0;
      else if (((r_state == S_DECODE) && w_illegal) || w_abort) r_error <= 1'b1;
      if ((r_state == S_DECODE) && !w_illegal)            r_busy <= 1'b1;
      else if ((r_state == S_FIN) || w_abort)             r_busy <= 1'b0;
      if ((r_state == S_DECODE) && !w_illegal && (r_cmd != OP_COPY)) begin
        r_op_sel <= r_cmd[1:0];
        r_angle  <= (r_cmd == OP_ROTATE) ? r_data[6:0] : '0;
      end
    end
  end

  assign busy   = r_busy;
  assign error  = r_error;
  assign op_sel = r_op_sel;
  assign angle  = r_angle;

endmodule

// File: tb/tb_imgproc_seq.sv
// Directed self-checking bench for imgproc_seq; inputs driven and outputs sampled on the falling edge.
module tb_imgproc_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cmd;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ack, busy, refresh, error;
  logic [1:0] op_sel;
  logic [6:0] angle;
  logic       p0_start, p0_done, p1_start, p1_done;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack = 0, n_p0 = 0, n_p1 = 0, n_ref = 0;
  int s_ack, s_p0, s_p1, s_ref;

  always #5 clk = ~clk;

  imgproc_seq #(.ANGLE_MAX(90), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ack(cmd_ack), .busy(busy), .refresh(refresh), .error(error),
    .op_sel(op_sel), .angle(angle),
    .p0_start(p0_start), .p0_done(p0_done), .p1_start(p1_start), .p1_done(p1_done)
  );

  always @(posedge clk) begin
    if (cmd_ack)  n_ack++;
    if (p0_start) n_p0++;
    if (p1_start) n_p1++;
    if (refresh)  n_ref++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_ack = n_ack; s_p0 = n_p0; s_p1 = n_p1; s_ref = n_ref;
  endtask

  // Ends at the cycle after DECODE (GO state or IDLE on a rejected command).
  task automatic issue(input logic [3:0] c, input logic [7:0] d);
    cmd = c; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    check("ack_pulse", 32'(cmd_ack), 1);
    check("err_clr_decode", 32'(error), 0);
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pass0(input int dly);
    repeat (dly) @(negedge clk);
    p0_done = 1'b1;
    @(negedge clk);
    p0_done = 1'b0;
    check("p1_start_early", 32'(p1_start), 0);
    @(negedge clk);
    check("p1_start_m2", 32'(p1_start), 1);
    check("busy_p1go", 32'(busy), 1);
  endtask

  task automatic pass1(input int dly);
    int r0;
    r0 = n_ref;
    repeat (dly) @(negedge clk);
    p1_done = 1'b1;
    @(negedge clk);
    p1_done = 1'b0;
    check("refresh_early", 32'(refresh), 0);
    @(negedge clk);
    check("refresh_n2", 32'(refresh), 1);
    check("busy_in_fin", 32'(busy), 1);
    @(negedge clk);
    check("refresh_1cyc", 32'(refresh), 0);
    check("busy_fall", 32'(busy), 0);
    check("refresh_count", 32'(n_ref), 32'(r0 + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; cmd = '0; cmd_data = '0; cmd_valid = 1'b0;
    p0_done = 1'b0; p1_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(cmd_ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_refresh", 32'(refresh), 0);
    check("rst_error", 32'(error), 0);
    check("rst_op_sel", 32'(op_sel), 0);
    check("rst_angle", 32'(angle), 0);
    check("rst_p0_start", 32'(p0_start), 0);
    check("rst_p1_start", 32'(p1_start), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ROTATE 30
    issue(4'd0, 8'd30);
    check("rot_p0_start", 32'(p0_start), 1);
    check("rot_busy", 32'(busy), 1);
    check("rot_op_sel", 32'(op_sel), 0);
    check("rot_angle", 32'(angle), 30);
    check("rot_ack_one", 32'(cmd_ack), 0);
    pass0(10);
    pass1(10);
    check("rot_error", 32'(error), 0);

    // Illegal opcode, then GRAYSCALE with a done coincident with p0_start
    snap();
    issue(4'd5, 8'd0);
    check("ill_error", 32'(error), 1);
    check("ill_busy", 32'(busy), 0);
    check("ill_p0_start", 32'(p0_start), 0);
    repeat (3) @(negedge clk);
    check("ill_no_p0", 32'(n_p0), 32'(s_p0));
    check("ill_no_p1", 32'(n_p1), 32'(s_p1));
    check("ill_error_sticky", 32'(error), 1);
    issue(4'd1, 8'd77);
    check("gray_p0_start", 32'(p0_start), 1);
    check("gray_op_sel", 32'(op_sel), 1);
    check("gray_angle", 32'(angle), 0);
    p0_done = 1'b1;
    @(negedge clk);
    p0_done = 1'b0;
    repeat (3) @(negedge clk);
    check("same_cyc_done_ignored", 32'(p1_start), 0);
    check("same_cyc_busy", 32'(busy), 1);
    pass0(5);
    pass1(3);

    // Angle boundary
    issue(4'd0, 8'd91);
    check("a91_error", 32'(error), 1);
    check("a91_p0_start", 32'(p0_start), 0);
    check("a91_busy", 32'(busy), 0);
    issue(4'd0, 8'd90);
    check("a90_p0_start", 32'(p0_start), 1);
    check("a90_angle", 32'(angle), 90);
    check("a90_error", 32'(error), 0);
    pass0(2);
    pass1(2);

    // COPY keeps op_sel/angle
    issue(4'd2, 8'd5);
    check("copy_p1_start", 32'(p1_start), 1);
    check("copy_p0_start", 32'(p0_start), 0);
    check("copy_busy", 32'(busy), 1);
    check("copy_angle", 32'(angle), 90);
    check("copy_op_sel", 32'(op_sel), 0);
    pass1(4);

    // cmd_valid held while busy, stray p1_done in P0_WAIT
    issue(4'd0, 8'd45);
    check("busy_angle", 32'(angle), 45);
    cmd = 4'd1; cmd_data = 8'd0; cmd_valid = 1'b1;
    snap();
    repeat (3) @(negedge clk);
    p1_done = 1'b1;
    @(negedge clk);
    p1_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_p1_start", 32'(n_p1), 32'(s_p1));
    check("stray_refresh", 32'(n_ref), 32'(s_ref));
    check("stray_busy", 32'(busy), 1);
    pass0(1);
    pass1(2);
    check("held_no_ack", 32'(n_ack), 32'(s_ack));
    check("held_angle", 32'(angle), 45);
    @(negedge clk);
    check("reissue_ack", 32'(cmd_ack), 1);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("reissue_p0_start", 32'(p0_start), 1);
    check("reissue_op_sel", 32'(op_sel), 1);
    pass0(1);
    pass1(1);

    // Watchdog on a pass-0 that never completes
    issue(4'd0, 8'd10);
    check("wd_p0_start", 32'(p0_start), 1);
    snap();
`ifdef IMGPROC_SEQ_WATCHDOG_EN
    repeat (100) @(negedge clk);
    check("wd_busy_before", 32'(busy), 1);
    check("wd_error_before", 32'(error), 0);
    @(negedge clk);
    check("wd_busy_after", 32'(busy), 0);
    check("wd_error_after", 32'(error), 1);
    repeat (3) @(negedge clk);
    check("wd_no_p1", 32'(n_p1), 32'(s_p1));
    check("wd_no_refresh", 32'(n_ref), 32'(s_ref));
`else
    repeat (150) @(negedge clk);
    check("nowd_busy", 32'(busy), 1);
    check("nowd_error", 32'(error), 0);
    check("nowd_no_p1", 32'(n_p1), 32'(s_p1));
    pass0(1);
    pass1(1);
`endif

    // Reset during P1_WAIT
    issue(4'd2, 8'd0);
    check("rstm_p1_start", 32'(p1_start), 1);
    check("rstm_angle_kept", 32'(angle), 10);
    repeat (3) @(negedge clk);
    snap();
    rst_n = 1'b0;
    #1;
    check("rstm_busy", 32'(busy), 0);
    check("rstm_error", 32'(error), 0);
    check("rstm_angle", 32'(angle), 0);
    check("rstm_op_sel", 32'(op_sel), 0);
    check("rstm_refresh", 32'(refresh), 0);
    check("rstm_p1_start_0", 32'(p1_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p1_done = 1'b1;
    @(negedge clk);
    p1_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rstm_no_refresh", 32'(n_ref), 32'(s_ref));
    issue(4'd2, 8'd0);
    check("rstm_copy_p1_start", 32'(p1_start), 1);
    check("rstm_copy_busy", 32'(busy), 1);
    check("rstm_copy_angle", 32'(angle), 0);
    pass1(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
